// File: rtl/univ_shift_reg_if.sv
// Data/control bundle for univ_shift_reg. The controlling side takes the
// master modport; the shift register itself takes the slave modport.
interface univ_shift_reg_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic             sin;
   logic [WIDTH-1:0] i;
   logic [WIDTH-1:0] o;
   logic             sout;
   logic [CW-1:0]    cnt;
   logic             empty;

   modport master (output en, mode, sin, i, input o, sout, cnt, empty);
   modport slave  (input en, mode, sin, i, output o, sout, cnt, empty);
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shifts,
// rotates and synchronous clear, selected per cycle by a 3-bit mode.
// Tracks the registered serial output and the number of valid bits
// remaining, so one instance covers PIPO, SIPO, PISO and SISO use.
module univ_shift_reg #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   univ_shift_reg_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_LOAD = 3'b001,
      M_SHL  = 3'b010,
      M_SHR  = 3'b011,
      M_ROTL = 3'b100,
      M_ROTR = 3'b101,
      M_ASHR = 3'b110,
      M_CLR  = 3'b111
   } mode_e;

   mode_e            op;
   logic [WIDTH-1:0] o_q;
   logic             sout_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_dec;

   assign op = mode_e'(bus.mode);

   // Remaining-bit count after one shift; saturates at zero so shifting
   // an empty register is harmless.
   always_comb begin
      cnt_dec = cnt_q;
      if (cnt_q != '0) begin
         cnt_dec = cnt_q - CW'(1);
      end
   end

   // Register, serial-out and count update for the selected operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_q    <= RST_VAL;
         sout_q <= 1'b0;
         cnt_q  <= '0;
      end else if (bus.en) begin
         case (op)
            M_HOLD: begin
            end
            M_LOAD: begin
               o_q   <= bus.i;
               cnt_q <= CW'(WIDTH);
            end
            M_SHL: begin
               o_q    <= {o_q[WIDTH-2:0], bus.sin};
               sout_q <= o_q[WIDTH-1];
               cnt_q  <= cnt_dec;
            end
            M_SHR: begin
               o_q    <= {bus.sin, o_q[WIDTH-1:1]};
               sout_q <= o_q[0];
               cnt_q  <= cnt_dec;
            end
            M_ROTL: begin
               o_q    <= {o_q[WIDTH-2:0], o_q[WIDTH-1]};
               sout_q <= o_q[WIDTH-1];
            end
            M_ROTR: begin
               o_q    <= {o_q[0], o_q[WIDTH-1:1]};
               sout_q <= o_q[0];
            end
            M_ASHR: begin
               o_q    <= {o_q[WIDTH-1], o_q[WIDTH-1:1]};
               sout_q <= o_q[0];
               cnt_q  <= cnt_dec;
            end
            M_CLR: begin
               o_q    <= '0;
               sout_q <= 1'b0;
               cnt_q  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.o     = o_q;
   assign bus.sout  = sout_q;
   assign bus.cnt   = cnt_q;
   assign bus.empty = (cnt_q == '0);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios at WIDTH=4 and WIDTH=8,
// then random traffic, all checked against an arithmetic reference model.
module tb_univ_shift_reg;
   localparam logic [3:0] RV4 = 4'b1010;
   localparam logic [7:0] RV8 = 8'h3C;

   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                          ROTL = 3'd4, ROTR = 3'd5, ASHR = 3'd6, CLR = 3'd7;

   logic clk = 1'b0;
   logic rst4 = 1'b0;
   logic rst8 = 1'b0;
   bit   chk_on = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   univ_shift_reg_if #(.WIDTH(4)) b4 ();
   univ_shift_reg_if #(.WIDTH(8)) b8 ();

   univ_shift_reg #(.WIDTH(4), .RST_VAL(RV4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
   univ_shift_reg #(.WIDTH(8), .RST_VAL(RV8)) dut8 (.clk(clk), .rst(rst8), .bus(b8));

   // Reference model state, held as plain integers.
   bit [63:0] m4_o = 64'(RV4), m8_o = 64'(RV8);
   bit        m4_s = 1'b0, m8_s = 1'b0;
   int        m4_c = 0, m8_c = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_step(input int w, input logic [2:0] md, input bit s,
                                      input bit [63:0] din, inout bit [63:0] mo,
                                      inout bit ms, inout int mc);
      bit [63:0] mask;
      bit [63:0] msb;
      bit [63:0] lsb;
      mask = (64'd1 << w) - 64'd1;
      msb  = (mo >> (w - 1)) & 64'd1;
      lsb  = mo & 64'd1;
      case (md)
         LOAD: begin mo = din & mask; mc = w; end
         SHL:  begin ms = msb[0]; mo = ((mo << 1) | 64'(s)) & mask; end
         SHR:  begin ms = lsb[0]; mo = (mo >> 1) | (64'(s) << (w - 1)); end
         ROTL: begin ms = msb[0]; mo = ((mo << 1) | msb) & mask; end
         ROTR: begin ms = lsb[0]; mo = (mo >> 1) | (lsb << (w - 1)); end
         ASHR: begin ms = lsb[0]; mo = (mo >> 1) | (msb << (w - 1)); end
         CLR:  begin mo = 64'd0; ms = 1'b0; mc = 0; end
         default: ;
      endcase
      if ((md == SHL || md == SHR || md == ASHR) && mc > 0) mc = mc - 1;
   endfunction

   always @(posedge clk or negedge rst4) begin
      if (!rst4) begin m4_o = 64'(RV4); m4_s = 1'b0; m4_c = 0; end
      else if (b4.en) model_step(4, b4.mode, b4.sin, 64'(b4.i), m4_o, m4_s, m4_c);
   end

   always @(posedge clk or negedge rst8) begin
      if (!rst8) begin m8_o = 64'(RV8); m8_s = 1'b0; m8_c = 0; end
      else if (b8.en) model_step(8, b8.mode, b8.sin, 64'(b8.i), m8_o, m8_s, m8_c);
   end

   // Every cycle, away from the active edge, compare both DUTs to the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_o4",     64'(b4.o),     m4_o);
         chk("m_sout4",  64'(b4.sout),  64'(m4_s));
         chk("m_cnt4",   64'(b4.cnt),   64'(m4_c));
         chk("m_empty4", 64'(b4.empty), 64'(m4_c == 0));
         chk("m_o8",     64'(b8.o),     m8_o);
         chk("m_sout8",  64'(b8.sout),  64'(m8_s));
         chk("m_cnt8",   64'(b8.cnt),   64'(m8_c));
         chk("m_empty8", 64'(b8.empty), 64'(m8_c == 0));
      end
   end

   task automatic drv4(input bit e, input logic [2:0] m, input bit s, input logic [3:0] d);
      b4.en = e; b4.mode = m; b4.sin = s; b4.i = d;
   endtask

   task automatic drv8(input bit e, input logic [2:0] m, input bit s, input logic [7:0] d);
      b8.en = e; b8.mode = m; b8.sin = s; b8.i = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] sin_seq;
      logic [3:0] sout_seq;
      logic [7:0] pat;

      drv4(0, HOLD, 0, '0);
      drv8(0, HOLD, 0, '0);
      repeat (2) step();
      rst4 = 1'b1;
      rst8 = 1'b1;
      chk_on = 1'b1;

      // Reset asserted mid-shift, between edges.
      drv4(1, LOAD, 0, 4'b1011); step();
      chk("load_before_rst", 64'(b4.o), 64'hB);
      drv4(1, SHL, 0, '0); step();
      chk("sout_before_rst", 64'(b4.sout), 64'd1);
      rst4 = 1'b0;
      #1;
      chk("rst_o",     64'(b4.o),     64'(RV4));
      chk("rst_sout",  64'(b4.sout),  64'd0);
      chk("rst_cnt",   64'(b4.cnt),   64'd0);
      chk("rst_empty", 64'(b4.empty), 64'd1);
      #2;
      rst4 = 1'b1;
      drv4(1, HOLD, 0, 4'hF);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_after_rst", 64'(b4.o), 64'(RV4));
      end

      // PIPO sweep.
      for (int k = 0; k < 16; k++) begin
         drv4(1, LOAD, 0, 4'(k)); step();
         chk("pipo_o",   64'(b4.o),   64'(k));
         chk("pipo_cnt", 64'(b4.cnt), 64'd4);
      end

      // PISO/SIPO via SHL.
      drv4(1, LOAD, 0, 4'b1011); step();
      sin_seq  = 4'b0110;  // applied in order bit3..bit0
      sout_seq = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         drv4(1, SHL, sin_seq[3 - k], '0); step();
         chk("piso_sout", 64'(b4.sout), 64'(sout_seq[3 - k]));
         chk("piso_cnt",  64'(b4.cnt),  64'(3 - k));
      end
      chk("piso_o",     64'(b4.o),     64'b0110);
      chk("piso_empty", 64'(b4.empty), 64'd1);
      drv4(1, SHL, 0, '0); step();
      chk("piso_sat_cnt", 64'(b4.cnt), 64'd0);
      chk("piso_sat_o",   64'(b4.o),   64'b1100);

      // Shift and rotate variants.
      drv4(1, LOAD, 0, 4'b1001); step();
      drv4(1, ASHR, 0, '0); step();
      chk("ashr_o",    64'(b4.o),    64'b1100);
      chk("ashr_sout", 64'(b4.sout), 64'd1);
      drv4(1, ROTR, 0, '0); step();
      chk("rotr_o",   64'(b4.o),   64'b0110);
      chk("rotr_cnt", 64'(b4.cnt), 64'd3);
      drv4(1, ROTL, 0, '0); step();
      chk("rotl_o", 64'(b4.o), 64'b1100);
      drv4(1, SHR, 1, '0); step();
      chk("shr_o",    64'(b4.o),    64'b1110);
      chk("shr_sout", 64'(b4.sout), 64'd0);
      chk("shr_cnt",  64'(b4.cnt),  64'd2);

      // Enable and clear.
      drv4(1, LOAD, 0, 4'b0101); step();
      drv4(0, LOAD, 0, 4'b1111); step(); step();
      chk("en0_o",   64'(b4.o),   64'b0101);
      chk("en0_cnt", 64'(b4.cnt), 64'd4);
      drv4(1, SHL, 0, '0); step(); step();
      chk("pre_clr_cnt",  64'(b4.cnt),  64'd2);
      chk("pre_clr_sout", 64'(b4.sout), 64'd1);
      drv4(1, CLR, 1, 4'hF); step();
      chk("clr_o",    64'(b4.o),    64'd0);
      chk("clr_cnt",  64'(b4.cnt),  64'd0);
      chk("clr_sout", 64'(b4.sout), 64'd0);
      drv4(1, LOAD, 0, 4'b0011); step();
      chk("reload_cnt", 64'(b4.cnt), 64'd4);
      chk("reload_o",   64'(b4.o),   64'b0011);
      drv4(0, HOLD, 0, '0);

      // WIDTH=8 PISO.
      pat = 8'hA5;
      drv8(1, LOAD, 0, pat); step();
      chk("w8_load_cnt", 64'(b8.cnt), 64'd8);
      for (int k = 0; k < 8; k++) begin
         drv8(1, SHL, 1'($urandom), '0); step();
         chk("w8_sout",  64'(b8.sout),  64'(pat[7 - k]));
         chk("w8_cnt",   64'(b8.cnt),   64'(7 - k));
         chk("w8_empty", 64'(b8.empty), 64'(k == 7));
      end

      // Random traffic on both widths, with occasional mid-cycle resets.
      for (int n = 0; n < 400; n++) begin
         drv4($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 4'($urandom));
         drv8($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 8'($urandom));
         if ($urandom_range(0, 49) == 0) rst4 = 1'b0;
         if ($urandom_range(0, 49) == 0) rst8 = 1'b0;
         step();
         rst4 = 1'b1;
         rst8 = 1'b1;
      end
      drv4(0, HOLD, 0, '0);
      drv8(0, HOLD, 0, '0);
      step();
      @(negedge clk);
      #1;
      chk_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: a WIDTH-bit register with parallel load, logical and arithmetic shifts, rotates, and synchronous clear, selected per cycle by a mode code. It also registers a serial output and keeps a count of valid bits remaining, so one instance can serve as a PIPO, SIPO, PISO or SISO stage. It is the general-purpose replacement for the fixed 4-bit parallel-in/parallel-out register.

## Interface
- WIDTH, 4, register width in bits; legal range 2..64.
- RST_VAL, 0, value loaded into o on reset; WIDTH bits.
- CW, $clog2(WIDTH+1), width of cnt. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 holds all state.
- mode  in  3  operation select; see Operation.
- sin  in  1  serial input bit.
- i  in  WIDTH  parallel input.
- o  out  WIDTH  register contents (registered).
- sout  out  1  last bit shifted or rotated out (registered).
- cnt  out  CW  valid bits remaining (registered).
- empty  out  1  combinational, cnt == 0.

## Operation
- rst low, asynchronously: o = RST_VAL, sout = 0, cnt = 0. Outputs hold these values while rst stays low.
- When en = 0 or mode = 000, o, sout and cnt all hold.
- Mode encodings (applied at the clock edge when en = 1):
  - 000 HOLD: no change.
  - 001 LOAD: o <= i; cnt <= WIDTH; sout unchanged.
  - 010 SHL: o <= {o[W-2:0], sin}; sout <= o[W-1]; cnt decrements.
  - 011 SHR: o <= {sin, o[W-1:1]}; sout <= o[0]; cnt decrements.
  - 100 ROTL: o <= {o[W-2:0], o[W-1]}; sout <= o[W-1]; cnt unchanged.
  - 101 ROTR: o <= {o[0], o[W-1:1]}; sout <= o[0]; cnt unchanged.
  - 110 ASHR: o <= {o[W-1], o[W-1:1]}; sout <= o[0]; cnt decrements.
  - 111 CLR: o <= 0; sout <= 0; cnt <= 0.
- cnt decrement saturates at 0. Shifting while empty is legal: data still shifts and cnt stays 0.
- A LOAD sets cnt to WIDTH no matter what cnt was before, including mid-shift.
- sin is sampled only in SHL and SHR. i is sampled only in LOAD.
- Unknown or X on mode when en = 1 is a verification error. The RTL needs no defined behaviour for it.

## Timing
- Every registered output changes one cycle after the sampling edge. There is no other pipelining.
- empty follows cnt combinationally, with no additional latency.
- For PISO operation: a LOAD followed by WIDTH consecutive SHL (or SHR) cycles presents every loaded bit on sout. After the last shift, empty = 1.
- A rst assertion mid-sequence takes effect immediately and does not wait for clk. Deassertion is expected to be synchronous to clk at system level. The first active edge after release executes the mode present at that edge.
- No combinational path from inputs to o, sout or cnt.

## Test plan
- Reset: WIDTH=4, RST_VAL=4'b1010, rst low between clock edges. Required: o = 1010, sout = 0, cnt = 0, empty = 1 immediately. After release, HOLD for 3 cycles leaves o = 1010.
- PIPO sweep: LOAD i = 0..15 on consecutive cycles. Required: o equals the previous cycle's i, and cnt = 4 throughout.
- PISO/SIPO via SHL: LOAD 1011, then 4 cycles of SHL with sin = 0,1,1,0. Required: sout sequence 1,0,1,1; cnt sequence 3,2,1,0; final o = 0110; empty = 1 after the 4th shift. A 5th SHL keeps cnt = 0.
- Shift and rotate variants: LOAD 1001, then ASHR gives o = 1100 and sout = 1. Then ROTR gives o = 0110 with cnt unchanged at 3. Then ROTL gives o = 1100. Then SHR with sin = 1 gives o = 1110 and sout = 0.
- Enable and clear: with en = 0 and mode = LOAD i = 1111, o and cnt hold. CLR mid-shift (cnt = 2) gives o = 0, cnt = 0, sout = 0. A LOAD on the very next cycle restores cnt = 4.
- Reset mid-operation and width sweep: assert rst during a shift sequence; all outputs go to reset values at once. Repeat the SHL scenario at WIDTH = 8 (LOAD 8'hA5, 8 shifts) and check sout = 1,0,1,0,0,1,0,1 and that cnt reaches 0 exactly on the 8th shift.
